alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Parametrised successor to the single-cycle RV32I ALU control decode.
- Decodes alu_op/funct3/op/funct7 into an extended alu_t, executes the full RV32I ALU set plus optional M-extension ops, and returns a registered result through a valid/ready handshake.
- Base ALU ops complete with 1-cycle latency. MUL/DIV-class ops run on an iterative radix-2 engine with fixed latency XLEN+1.
- Sits in the execute stage. The core stalls on ready_o low.

Parameters:
- XLEN, 32, datapath width; must be a power of 2, at least 8.
- EN_M, 1, 1 enables M-extension ops; 0 makes M encodings illegal.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- flush_i  in  1  synchronous abort of any in-flight op.
- valid_i  in  1  operation request.
- ready_o  out  1  high when a request can be accepted.
- alu_op_i  in  2  main-decoder class: 00 add, 01 sub, 10 funct-decoded, 11 pass B.
- funct3_i  in  3  instruction funct3.
- op_i  in  1  opcode bit 5: 1 = R-type, 0 = I-type.
- funct7_i  in  7  instruction funct7 (imm[11:5] for I-type).
- a_i  in  XLEN  operand A.
- b_i  in  XLEN  operand B.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  XLEN  result, held until next valid_o.
- zero_o  out  1  result_o == 0, registered with result_o.
- illegal_o  out  1  undefined encoding; qualified by valid_o.

Behaviour:
- Reset (rst_ni=0 at an edge): state IDLE; valid_o=0, illegal_o=0, result_o=0, zero_o=1, ready_o=1 after the edge. Reset overrides flush_i and valid_i.
- Accept happens on a rising edge with valid_i & ready_o. ready_o = (state==IDLE); it is never high in BUSY.
- Decode for alu_op=10, op=1:
  - funct7=0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by funct3.
  - funct7=0100000: funct3 000 SUB, 101 SRA; all else ILLEGAL.
  - funct7=0000001 with EN_M: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3; ILLEGAL when EN_M=0.
  - Any other funct7: ILLEGAL.
- Decode for alu_op=10, op=0:
  - funct3 000/010/011/100/110/111 are ADD/SLT/SLTU/XOR/OR/AND; funct7 is ignored.
  - 001 is SLL only if funct7=0.
  - 101 is SRL if funct7=0, SRA if funct7=0100000.
  - All else ILLEGAL.
- Decode for alu_op 00/01/11: ADD/SUB/PASSB, independent of funct fields.
- Shifts use b_i[$clog2(XLEN)-1:0]. SLT is signed, SLTU unsigned; result is 0 or 1 zero-extended.
- Base op or ILLEGAL accepted at edge k:
  - Result registered at edge k; valid_o high for the cycle after k.
  - ILLEGAL gives result_o=0, illegal_o=1.
  - State stays IDLE, so back-to-back accepts every cycle are allowed.
- M op accepted at edge k:
  - Operands latched; magnitudes taken per signedness (MULHSU: A signed, B unsigned); state BUSY; counter=0.
  - Edges k+1..k+XLEN perform one iteration each: shift-add (2*XLEN product) or restoring divide.
  - At edge k+XLEN+1: sign correction, result registered, valid_o high for one cycle, state IDLE.
  - ready_o low for XLEN+1 cycles.
- MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Division sign rules: quotient is negated when operand signs differ (signed ops); remainder takes the dividend's sign.
- Divisor 0: quotient all-ones, remainder = dividend.
- Signed overflow (MIN / -1): quotient MIN, remainder 0.
- Special cases keep the fixed XLEN+1 latency.
- flush_i at an edge: state IDLE, counter cleared, no valid_o for the aborted op; result_o retains its old value. A request with valid_i in the same edge as flush_i is dropped.
- valid_o is never high in two consecutive cycles for one op. It is low every cycle with no completion.

Decomposition:
- definitions_pkg:
  - Extend alu_t (5-bit): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, ILLEGAL.
  - Add md_state_t {IDLE, BUSY}.
  - Add funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
- Sub-module muldiv_seq: iterative engine with start/done, parametrised by XLEN, containing its own counter.
- alu_unit holds the decoder, the base ALU, the handshake and the output registers.

Test Plan:
- R-type ADD a=5, b=7 -> valid_o next cycle, result 12, zero_o 0. Next cycle SRA a=0x80000000, b=4 -> 0xF8000000. I-type SUB encoding (op=0, funct3 000, funct7 0100000) -> ADD.
- MUL a=0xFFFFFFFD, b=7 -> ready_o low 33 cycles, valid_o 33 edges after accept, result 0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 0x1234/0 -> 0xFFFFFFFF; REM -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; all at latency 33.
- op=1, funct7=0100000, funct3=001 -> valid_o, illegal_o=1, result 0. With EN_M=0, MUL encoding -> illegal in 1 cycle.
- DIV accepted, flush_i at cycle 10 -> ready_o high next cycle, no valid_o; the following ADD completes normally. Repeat with rst_ni=0 mid-MUL -> all outputs at reset values.
- XLEN=16: MUL 0x00FF*0x0101 -> 0xFFFF at latency 17; SLL shift uses b[3:0] (b=0x0011 shifts by 1).

Source files
------------

// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
// Module      : definitions_pkg
// Description : Shared ALU operation encoding, mul/div state encoding and the
//               alu_op/funct3/op/funct7 decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package definitions_pkg;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU,
        ALU_ILLEGAL
    } alu_t;

    typedef logic [0:0] md_state_t;
    localparam md_state_t c_IDLE = 1'b0;
    localparam md_state_t c_BUSY = 1'b1;

    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    function automatic logic is_muldiv(input alu_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic alu_t decode_alu(
        input logic [1:0] alu_op,
        input logic [2:0] funct3,
        input logic       op_r,
        input logic [6:0] funct7,
        input logic       en_m
    );
        alu_t res;
        res = ALU_ILLEGAL;
        case (alu_op)
            2'b00:   res = ALU_ADD;
            2'b01:   res = ALU_SUB;
            2'b11:   res = ALU_PASSB;
            default: begin
                if (op_r) begin
                    if (funct7 == c_F7_BASE) begin
                        case (funct3)
                            3'b000:  res = ALU_ADD;
                            3'b001:  res = ALU_SLL;
                            3'b010:  res = ALU_SLT;
                            3'b011:  res = ALU_SLTU;
                            3'b100:  res = ALU_XOR;
                            3'b101:  res = ALU_SRL;
                            3'b110:  res = ALU_OR;
                            default: res = ALU_AND;
                        endcase
                    end else if (funct7 == c_F7_ALT) begin
                        if (funct3 == 3'b000)      res = ALU_SUB;
                        else if (funct3 == 3'b101) res = ALU_SRA;
                    end else if ((funct7 == c_F7_MULDIV) && en_m) begin
                        case (funct3)
                            3'b000:  res = ALU_MUL;
                            3'b001:  res = ALU_MULH;
                            3'b010:  res = ALU_MULHSU;
                            3'b011:  res = ALU_MULHU;
                            3'b100:  res = ALU_DIV;
                            3'b101:  res = ALU_DIVU;
                            3'b110:  res = ALU_REM;
                            default: res = ALU_REMU;
                        endcase
                    end
                end else begin
                    // I-type: funct7 is immediate bits, only the shifts look at it
                    case (funct3)
                        3'b000:  res = ALU_ADD;
                        3'b001:  if (funct7 == c_F7_BASE) res = ALU_SLL;
                        3'b010:  res = ALU_SLT;
                        3'b011:  res = ALU_SLTU;
                        3'b100:  res = ALU_XOR;
                        3'b101: begin
                            if (funct7 == c_F7_BASE)     res = ALU_SRL;
                            else if (funct7 == c_F7_ALT) res = ALU_SRA;
                        end
                        3'b110:  res = ALU_OR;
                        default: res = ALU_AND;
                    endcase
                end
            end
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative radix-2 multiply / restoring divide, fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import definitions_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_start,
    input  alu_t            i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int              c_CW   = $clog2(XLEN) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN);

    logic              r_busy;
    logic [c_CW-1:0]   r_cnt;
    alu_t              r_op;
    logic              r_neg;
    logic              r_dz;
    logic [XLEN-1:0]   r_dvd;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;

    logic              w_sa;
    logic              w_sb;
    logic              w_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_is_div;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    assign w_sa    = (i_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) & i_a[XLEN-1];
    assign w_sb    = (i_op inside {ALU_MULH, ALU_DIV, ALU_REM}) & i_b[XLEN-1];
    assign w_mag_a = w_sa ? -i_a : i_a;
    assign w_mag_b = w_sb ? -i_b : i_b;
    // Remainder follows the dividend; everything else follows the sign product
    assign w_neg   = (i_op == ALU_REM) ? w_sa : (w_sa ^ w_sb);

    assign w_is_div = r_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    assign o_done = r_busy && (r_cnt == c_LAST);

    always_comb begin
        o_result = '0;
        case (r_op)
            ALU_MUL:                        o_result = w_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:              o_result = r_dz ? '1 : w_quo;
            ALU_REM, ALU_REMU:              o_result = r_dz ? r_dvd : w_rem;
            default:                        o_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            if (o_done) r_busy <= 1'b0;
            else        r_cnt  <= r_cnt + c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_op   <= i_op;
            r_neg  <= w_neg;
            r_dz   <= (i_b == '0);
            r_dvd  <= i_a;
            r_opnd <= w_mag_b;
            r_acc  <= {{XLEN{1'b0}}, w_mag_a};
        end else if (r_busy && !o_done) begin
            r_acc <= w_is_div ? w_div_next : w_mul_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit
// Description : RV32I(+M) ALU with decode, registered result and valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_unit
    import definitions_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      alu_op_i,
    input  logic [2:0]      funct3_i,
    input  logic            op_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam int c_SHW = $clog2(XLEN);

    md_state_t       r_state;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    alu_t             w_op;
    logic             w_is_md;
    logic             w_start;
    logic [c_SHW-1:0] w_shamt;
    logic [XLEN-1:0]  w_base_res;
    logic             w_md_done;
    logic [XLEN-1:0]  w_md_result;

    assign w_op    = decode_alu(alu_op_i, funct3_i, op_i, funct7_i, EN_M);
    assign w_is_md = is_muldiv(w_op);
    assign w_start = valid_i && ready_o && !flush_i && w_is_md;
    assign w_shamt = b_i[c_SHW-1:0];

    always_comb begin
        w_base_res = '0;
        case (w_op)
            ALU_ADD:   w_base_res = a_i + b_i;
            ALU_SUB:   w_base_res = a_i - b_i;
            ALU_SLL:   w_base_res = a_i << w_shamt;
            ALU_SLT:   w_base_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  w_base_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:   w_base_res = a_i ^ b_i;
            ALU_SRL:   w_base_res = a_i >> w_shamt;
            ALU_SRA:   w_base_res = $signed(a_i) >>> w_shamt;
            ALU_OR:    w_base_res = a_i | b_i;
            ALU_AND:   w_base_res = a_i & b_i;
            ALU_PASSB: w_base_res = b_i;
            default:   w_base_res = '0;
        endcase
    end

    generate
        if (EN_M) begin : g_muldiv
            muldiv_seq #(
                .XLEN(XLEN)
            ) u_muldiv (
                .clk      (clk_i),
                .rst_n    (rst_ni),
                .i_flush  (flush_i),
                .i_start  (w_start),
                .i_op     (w_op),
                .i_a      (a_i),
                .i_b      (b_i),
                .o_done   (w_md_done),
                .o_result (w_md_result)
            );
        end else begin : g_no_muldiv
            assign w_md_done   = 1'b0;
            assign w_md_result = '0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= c_IDLE;
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            // Result is deliberately kept; only the in-flight op is dropped
            r_state <= c_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (valid_i) begin
                        if (w_is_md) begin
                            r_state <= c_BUSY;
                        end else begin
                            r_result  <= w_base_res;
                            r_zero    <= (w_base_res == '0);
                            r_illegal <= (w_op == ALU_ILLEGAL);
                            r_valid   <= 1'b1;
                        end
                    end
                end
                c_BUSY: begin
                    if (w_md_done) begin
                        r_result  <= w_md_result;
                        r_zero    <= (w_md_result == '0);
                        r_illegal <= 1'b0;
                        r_valid   <= 1'b1;
                        r_state   <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ready_o   = (r_state == c_IDLE);
    assign valid_o   = r_valid;
    assign result_o  = r_result;
    assign zero_o    = r_zero;
    assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Directed-vector self-checking bench for alu_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        op = 1'b0;
    logic [6:0]  funct7 = 7'h00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        ready, vld, zero, ill;
    logic [31:0] res;
    logic        ready_nm, vld_nm, zero_nm, ill_nm;
    logic [31:0] res_nm;
    logic        ready_16, vld_16, zero_16, ill_16;
    logic [15:0] res_16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_unit #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready), .alu_op_i(alu_op), .funct3_i(funct3), .op_i(op),
        .funct7_i(funct7), .a_i(a), .b_i(b), .valid_o(vld), .result_o(res),
        .zero_o(zero), .illegal_o(ill)
    );

    alu_unit #(.XLEN(32), .EN_M(1'b0)) dut_nm (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_nm), .alu_op_i(alu_op), .funct3_i(funct3), .op_i(op),
        .funct7_i(funct7), .a_i(a), .b_i(b), .valid_o(vld_nm), .result_o(res_nm),
        .zero_o(zero_nm), .illegal_o(ill_nm)
    );

    alu_unit #(.XLEN(16), .EN_M(1'b1)) dut_16 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_16), .alu_op_i(alu_op), .funct3_i(funct3), .op_i(op),
        .funct7_i(funct7), .a_i(a[15:0]), .b_i(b[15:0]), .valid_o(vld_16),
        .result_o(res_16), .zero_o(zero_16), .illegal_o(ill_16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic o,
                         input logic [6:0] f7, input logic [31:0] va, input logic [31:0] vb);
        alu_op  = aop;
        funct3  = f3;
        op      = o;
        funct7  = f7;
        a       = va;
        b       = vb;
        valid_i = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_res, input logic exp_ill);
        check({tag, ".valid"}, {31'b0, vld}, 32'd1);
        check({tag, ".res"}, res, exp_res);
        check({tag, ".ill"}, {31'b0, ill}, {31'b0, exp_ill});
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'd0)});
    endtask

    task automatic run_base(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                            input logic o, input logic [6:0] f7, input logic [31:0] va,
                            input logic [31:0] vb, input logic [31:0] exp_res, input logic exp_ill);
        drive(aop, f3, o, f7, va, vb);
        tick();
        valid_i = 1'b0;
        check_out(tag, exp_res, exp_ill);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(ready && ready_16) && guard < 60) begin
            tick();
            guard++;
        end
        check("wait_idle.timeout", {31'b0, (guard < 60)}, 32'd1);
        tick();
    endtask

    task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_res);
        int lat;
        int lo;
        drive(2'b10, f3, 1'b1, 7'h01, va, vb);
        tick();
        valid_i = 1'b0;
        lat = 0;
        lo  = 0;
        while (!vld && lat < 60) begin
            if (!ready) lo++;
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, 32'd33);
        check({tag, ".busy"}, lo, 32'd33);
        check({tag, ".res"}, res, exp_res);
        check({tag, ".ill"}, {31'b0, ill}, 32'd0);
        tick();
        check({tag, ".pulse"}, {31'b0, vld}, 32'd0);
    endtask

    initial begin
        int pulses;
        int lat16;
        int guard;
        logic [31:0] held;

        tick();
        tick();
        check("rst.valid", {31'b0, vld}, 32'd0);
        check("rst.ill", {31'b0, ill}, 32'd0);
        check("rst.res", res, 32'd0);
        check("rst.zero", {31'b0, zero}, 32'd1);
        check("rst.ready", {31'b0, ready}, 32'd1);
        rst_ni = 1'b1;
        tick();
        check("idle.valid", {31'b0, vld}, 32'd0);

        // back-to-back base ops
        drive(2'b10, 3'b000, 1'b1, 7'h00, 32'd5, 32'd7);
        tick();
        check_out("add", 32'd12, 1'b0);
        check("add.ready", {31'b0, ready}, 32'd1);
        drive(2'b10, 3'b101, 1'b1, 7'h20, 32'h8000_0000, 32'd4);
        tick();
        valid_i = 1'b0;
        check_out("sra", 32'hF800_0000, 1'b0);
        tick();
        check("sra.pulse", {31'b0, vld}, 32'd0);

        run_base("i_sub_enc", 2'b10, 3'b000, 1'b0, 7'h20, 32'd10, 32'd3, 32'd13, 1'b0);
        run_base("sub", 2'b01, 3'b111, 1'b1, 7'h7F, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_base("passb", 2'b11, 3'b010, 1'b0, 7'h01, 32'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run_base("slt", 2'b10, 3'b010, 1'b1, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        run_base("sltu", 2'b10, 3'b011, 1'b1, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        run_base("sll", 2'b10, 3'b001, 1'b1, 7'h00, 32'd3, 32'h21, 32'd6, 1'b0);
        run_base("srli", 2'b10, 3'b101, 1'b0, 7'h00, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
        run_base("xori", 2'b10, 3'b100, 1'b0, 7'h55, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0);
        run_base("and", 2'b10, 3'b111, 1'b1, 7'h00, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
        run_base("ori", 2'b10, 3'b110, 1'b0, 7'h3C, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0);
        run_base("ill_r_alt", 2'b10, 3'b001, 1'b1, 7'h20, 32'd9, 32'd9, 32'd0, 1'b1);
        run_base("ill_i_sll", 2'b10, 3'b001, 1'b0, 7'h20, 32'd9, 32'd1, 32'd0, 1'b1);
        run_base("ill_r_f7", 2'b10, 3'b000, 1'b1, 7'h7F, 32'd9, 32'd1, 32'd0, 1'b1);
        run_base("after_ill", 2'b00, 3'b000, 1'b0, 7'h00, 32'd2, 32'd2, 32'd4, 1'b0);

        // M encoding on the EN_M=0 instance completes as illegal in one cycle
        drive(2'b10, 3'b000, 1'b1, 7'h01, 32'd6, 32'd7);
        tick();
        valid_i = 1'b0;
        check("nm.valid", {31'b0, vld_nm}, 32'd1);
        check("nm.ill", {31'b0, ill_nm}, 32'd1);
        check("nm.res", res_nm, 32'd0);
        check("nm.ready", {31'b0, ready_nm}, 32'd1);
        check("m.ready_low", {31'b0, ready}, 32'd0);
        wait_idle();

        run_m("mul", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
        run_m("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_m("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        run_m("mulh", 3'b001, 32'h4000_0000, 32'd4, 32'd1);
        run_m("mulh_neg", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        run_m("div0", 3'b100, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        run_m("rem0", 3'b110, 32'h1234, 32'd0, 32'h1234);
        run_m("div0_neg", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_m("rem0_neg", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run_m("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_m("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_m("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_m("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_m("divu", 3'b101, 32'd100, 32'd7, 32'd14);
        run_m("remu", 3'b111, 32'd100, 32'd7, 32'd2);

        // flush ten cycles into a divide
        held = 32'd2;
        drive(2'b10, 3'b100, 1'b1, 7'h01, 32'd100, 32'd7);
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush.ready", {31'b0, ready}, 32'd1);
        check("flush.valid", {31'b0, vld}, 32'd0);
        check("flush.res_held", res, held);
        pulses = 0;
        repeat (40) begin
            tick();
            if (vld) pulses++;
        end
        check("flush.no_valid", pulses, 32'd0);
        run_base("flush.add", 2'b10, 3'b000, 1'b1, 7'h00, 32'd3, 32'd4, 32'd7, 1'b0);

        // request coincident with flush is dropped
        drive(2'b00, 3'b000, 1'b0, 7'h00, 32'd1, 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_req.valid", {31'b0, vld}, 32'd0);
        check("flush_req.res", res, 32'd7);

        // reset in the middle of a multiply
        drive(2'b10, 3'b000, 1'b1, 7'h01, 32'd6, 32'd7);
        tick();
        valid_i = 1'b0;
        repeat (5) tick();
        rst_ni = 1'b0;
        tick();
        check("mrst.valid", {31'b0, vld}, 32'd0);
        check("mrst.ill", {31'b0, ill}, 32'd0);
        check("mrst.res", res, 32'd0);
        check("mrst.zero", {31'b0, zero}, 32'd1);
        check("mrst.ready", {31'b0, ready}, 32'd1);
        rst_ni = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (vld) pulses++;
        end
        check("mrst.no_valid", pulses, 32'd0);

        // 16-bit instance: latency XLEN+1 and 4-bit shift amount
        drive(2'b10, 3'b000, 1'b1, 7'h01, 32'h00FF, 32'h0101);
        tick();
        valid_i = 1'b0;
        lat16 = 0;
        while (!vld_16 && lat16 < 60) begin
            tick();
            lat16++;
        end
        check("x16.mul.lat", lat16, 32'd17);
        check("x16.mul.res", {16'b0, res_16}, 32'h0000_FFFF);
        guard = 0;
        while (!vld && guard < 60) begin
            tick();
            guard++;
        end
        check("x32.mul.res", res, 32'h0000_FFFF);
        tick();
        drive(2'b10, 3'b001, 1'b1, 7'h00, 32'd1, 32'h0011);
        tick();
        valid_i = 1'b0;
        check("x16.sll.valid", {31'b0, vld_16}, 32'd1);
        check("x16.sll.res", {16'b0, res_16}, 32'd2);
        check("x32.sll.res", res, 32'h0002_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
